// File: rtl/shift_dispatch_pkg.sv
// Shared definitions for the shift dispatcher: widths, direction codes,
// FSM state type and the packed command record stored in the FIFO.
package shift_dispatch_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned AMT_W  = 6;
    localparam int unsigned CMD_W  = DATA_W + AMT_W + 1;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] operand;
        logic [AMT_W-1:0]  amount;
        logic              dir;
    } cmd_t;

endpackage

// File: rtl/shift_dispatch_if.sv
// Command, shifter and response signals of the shift dispatcher.
// slave: the dispatcher side; master: the environment (producer, shifter, consumer).
interface shift_dispatch_if;
    import shift_dispatch_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_operand;
    logic [AMT_W-1:0]  cmd_amount;
    logic              cmd_dir;
    logic [DATA_W-1:0] sh_operand;
    logic [DATA_W-1:0] sh_amount;
    logic              sh_dir;
    logic              sh_control;
    logic [DATA_W-1:0] sh_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    modport slave (
        input  cmd_valid, cmd_operand, cmd_amount, cmd_dir, sh_result, rsp_ready,
        output cmd_ready, sh_operand, sh_amount, sh_dir, sh_control,
               rsp_valid, rsp_data, busy
    );

    modport master (
        output cmd_valid, cmd_operand, cmd_amount, cmd_dir, sh_result, rsp_ready,
        input  cmd_ready, sh_operand, sh_amount, sh_dir, sh_control,
               rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/shift_cmd_fifo.sv
// Synchronous command FIFO; power-of-two depth, pointers wrap naturally.
// Push while full and pop while empty are ignored.
module shift_cmd_fifo
    import shift_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = CMD_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer advance and occupancy tracking; simultaneous push+pop keeps the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/shift_dispatch.sv
// Queues shift commands and issues them one at a time to an external shifter:
// pop -> one-cycle strobe -> wait SHIFT_LATENCY cycles -> capture -> hold until consumed.
module shift_dispatch
    import shift_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SHIFT_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    shift_dispatch_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (SHIFT_LATENCY > 1) ? $clog2(SHIFT_LATENCY) : 1;

    state_t            r_state;
    state_t            w_state_nx;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [AW:0]       w_count;
    cmd_t              w_push_cmd;
    cmd_t              w_head;
    logic [CW-1:0]     r_wait_cnt;
    logic [DATA_W-1:0] r_sh_operand;
    logic [AMT_W-1:0]  r_sh_amount;
    logic              r_sh_dir;
    logic [DATA_W-1:0] r_rsp_data;
    logic              w_wait_done;

    assign w_push_cmd = '{operand: bus.cmd_operand, amount: bus.cmd_amount, dir: bus.cmd_dir};

    shift_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (bus.cmd_valid),
        .i_wdata (w_push_cmd),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_wait_done = (r_state == ST_WAIT) && (r_wait_cnt == '0);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    // Next-state decode; the pop is issued only from IDLE so one command is in flight.
    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nx = ST_ISSUE;
                    w_pop      = 1'b1;
                end
            end
            ST_ISSUE: w_state_nx = ST_WAIT;
            ST_WAIT:  if (w_wait_done) w_state_nx = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    // Shifter operand latch, wait down-counter and response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_operand <= '0;
            r_sh_amount  <= '0;
            r_sh_dir     <= DIR_RIGHT;
            r_wait_cnt   <= '0;
            r_rsp_data   <= '0;
        end else begin
            if (w_pop) begin
                r_sh_operand <= w_head.operand;
                r_sh_amount  <= w_head.amount;
                r_sh_dir     <= w_head.dir;
            end
            if (r_state == ST_ISSUE)
                r_wait_cnt <= CW'(SHIFT_LATENCY - 1);
            else if (r_state == ST_WAIT && r_wait_cnt != '0)
                r_wait_cnt <= r_wait_cnt - CW'(1);
            if (w_wait_done)
                r_rsp_data <= bus.sh_result;
        end
    end

    assign bus.cmd_ready  = !w_full;
    assign bus.sh_operand = r_sh_operand;
    assign bus.sh_amount  = {{(DATA_W-AMT_W){1'b0}}, r_sh_amount};
    assign bus.sh_dir     = r_sh_dir;
    assign bus.sh_control = (r_state == ST_ISSUE);
    assign bus.rsp_valid  = (r_state == ST_RESP);
    assign bus.rsp_data   = r_rsp_data;
    assign bus.busy       = (w_count != '0) || (r_state != ST_IDLE);

endmodule

// File: tb/tb_shift_dispatch.sv
// Directed bench for shift_dispatch (DEPTH 4, SHIFT_LATENCY 1); the bench plays the shifter.
module tb_shift_dispatch;
    import shift_dispatch_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    shift_dispatch_if u_if ();

    shift_dispatch #(
        .DEPTH         (4),
        .SHIFT_LATENCY (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_op  [32];
    logic [5:0]  exp_amt [32];
    logic        exp_dir [32];
    int          n_pushed = 0;
    int          n_issued = 0;
    int          n_resp   = 0;
    int          inflight = 0;
    logic        prev_ctrl = 1'b0;
    int          w;

    function automatic logic [63:0] model_res(input int j);
        return exp_op[j] ^ 64'hF0F0_0000_0000_0000 ^ 64'(j);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock with shifter emulation: checks every strobe against the push log
    // and every consumed response against the result the bench handed back.
    task automatic tick_mon();
        if (u_if.rsp_valid === 1'b1 && u_if.rsp_ready === 1'b1) begin
            chk("rsp_data_order", u_if.rsp_data, model_res(inflight));
            n_resp++;
        end
        step();
        if (u_if.sh_control === 1'b1) begin
            chk1("strobe_single_cycle", prev_ctrl, 1'b0);
            chk1("issue_has_pending", (n_issued < n_pushed), 1'b1);
            if (n_issued < n_pushed) begin
                chk("issue_operand", u_if.sh_operand, exp_op[n_issued]);
                chk("issue_amount", u_if.sh_amount, 64'(exp_amt[n_issued]));
                chk1("issue_dir", u_if.sh_dir, exp_dir[n_issued]);
                u_if.sh_result = model_res(n_issued);
                inflight = n_issued;
                n_issued++;
            end
        end
        prev_ctrl = u_if.sh_control;
    endtask

    task automatic push_cmd(input logic [63:0] op, input logic [5:0] amt, input logic dir,
                            output int waits);
        u_if.cmd_operand = op;
        u_if.cmd_amount  = amt;
        u_if.cmd_dir     = dir;
        u_if.cmd_valid   = 1'b1;
        waits = 0;
        while (u_if.cmd_ready !== 1'b1 && waits < 50) begin
            tick_mon();
            waits++;
        end
        if (waits >= 50) begin
            chk("push_timeout", 64'(waits), 64'd0);
        end else begin
            exp_op[n_pushed]  = op;
            exp_amt[n_pushed] = amt;
            exp_dir[n_pushed] = dir;
            n_pushed++;
            tick_mon();
        end
        u_if.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && n_resp < n_pushed; i++) tick_mon();
        chk("drain_count", 64'(n_resp), 64'(n_pushed));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset            = 1'b1;
        u_if.cmd_valid   = 1'b0;
        u_if.cmd_operand = '0;
        u_if.cmd_amount  = '0;
        u_if.cmd_dir     = 1'b0;
        u_if.sh_result   = '0;
        u_if.rsp_ready   = 1'b0;
        step();
        step();

        // Reset state
        chk1("rst_cmd_ready", u_if.cmd_ready, 1'b1);
        chk1("rst_busy", u_if.busy, 1'b0);
        chk1("rst_sh_control", u_if.sh_control, 1'b0);
        chk1("rst_rsp_valid", u_if.rsp_valid, 1'b0);
        chk("rst_sh_operand", u_if.sh_operand, 64'd0);
        chk("rst_rsp_data", u_if.rsp_data, 64'd0);
        reset = 1'b0;
        step();

        // Scenario 1: single command, strobe and shifter inputs
        u_if.cmd_operand = 64'hDB6D_B6DB_6DB6_DB6D;
        u_if.cmd_amount  = 6'h16;
        u_if.cmd_dir     = DIR_RIGHT;
        u_if.cmd_valid   = 1'b1;
        chk1("s1_ready_before", u_if.cmd_ready, 1'b1);
        step();                                    // edge k: accept
        u_if.cmd_valid = 1'b0;
        chk1("s1_k_no_strobe", u_if.sh_control, 1'b0);
        chk1("s1_k_busy", u_if.busy, 1'b1);
        step();                                    // edge k+1: pop, ISSUE
        chk1("s1_strobe", u_if.sh_control, 1'b1);
        chk("s1_sh_operand", u_if.sh_operand, 64'hDB6D_B6DB_6DB6_DB6D);
        chk("s1_sh_amount", u_if.sh_amount, 64'h0000_0000_0000_0016);
        chk1("s1_sh_dir", u_if.sh_dir, 1'b0);
        u_if.sh_result = 64'hFFFF_FF6D_B6DB_6DB6;
        u_if.rsp_ready = 1'b1;
        step();                                    // edge k+2: WAIT
        chk1("s1_strobe_one_cycle", u_if.sh_control, 1'b0);
        chk1("s2_no_early_valid", u_if.rsp_valid, 1'b0);
        step();                                    // edge k+3: capture, RESP
        // Scenario 2: response timing and data
        chk1("s2_rsp_valid", u_if.rsp_valid, 1'b1);
        chk("s2_rsp_data", u_if.rsp_data, 64'hFFFF_FF6D_B6DB_6DB6);
        chk1("s2_no_strobe_resp", u_if.sh_control, 1'b0);
        step();                                    // edge k+4: IDLE
        chk1("s2_rsp_valid_one_cycle", u_if.rsp_valid, 1'b0);
        chk1("s2_idle_busy", u_if.busy, 1'b0);
        chk("s2_operand_held", u_if.sh_operand, 64'hDB6D_B6DB_6DB6_DB6D);

        // Scenario 3: five back-to-back pushes with consumer stalled
        u_if.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(64'hA5A5_0000_0000_0000 | 64'(i), 6'(i + 1), 1'(i), w);
            chk("s3_accept_no_wait", 64'(w), 64'd0);
        end
        chk1("s3_ready_low_full", u_if.cmd_ready, 1'b0);
        chk1("s3_first_in_resp", u_if.rsp_valid, 1'b1);
        u_if.cmd_operand = 64'hDEAD_DEAD_DEAD_DEAD;
        u_if.cmd_valid   = 1'b1;

        // Scenario 4: consumer stalled for 10 cycles in RESP
        for (int i = 0; i < 10; i++) begin
            tick_mon();
            chk1("s4_rsp_valid_held", u_if.rsp_valid, 1'b1);
            chk("s4_rsp_data_held", u_if.rsp_data, model_res(0));
            chk1("s4_no_strobe", u_if.sh_control, 1'b0);
            chk1("s4_ready_low", u_if.cmd_ready, 1'b0);
        end
        u_if.cmd_valid = 1'b0;
        u_if.rsp_ready = 1'b1;
        drain();
        chk("s3_all_issued", 64'(n_issued), 64'(n_pushed));
        chk1("s3_idle_after_drain", u_if.busy, 1'b0);

        // Scenario 5: reset during WAIT with three commands queued
        u_if.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(64'h5555_0000_0000_0000 | 64'(i), 6'(10 + i), DIR_RIGHT, w);
        end
        u_if.rsp_ready = 1'b1;
        tick_mon();                                // RESP -> IDLE
        u_if.rsp_ready = 1'b0;
        tick_mon();                                // IDLE -> ISSUE
        chk1("s5_strobe", u_if.sh_control, 1'b1);
        tick_mon();                                // ISSUE -> WAIT
        chk1("s5_wait_no_strobe", u_if.sh_control, 1'b0);
        chk1("s5_wait_no_valid", u_if.rsp_valid, 1'b0);
        chk1("s5_wait_busy", u_if.busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("s5_rst_sh_operand", u_if.sh_operand, 64'd0);
        chk("s5_rst_sh_amount", u_if.sh_amount, 64'd0);
        chk1("s5_rst_sh_dir", u_if.sh_dir, 1'b0);
        chk1("s5_rst_sh_control", u_if.sh_control, 1'b0);
        chk("s5_rst_rsp_data", u_if.rsp_data, 64'd0);
        chk1("s5_rst_rsp_valid", u_if.rsp_valid, 1'b0);
        chk1("s5_rst_busy", u_if.busy, 1'b0);
        chk1("s5_rst_cmd_ready", u_if.cmd_ready, 1'b1);
        step();
        step();
        reset = 1'b0;
        n_issued  = n_pushed;
        n_resp    = n_pushed;
        prev_ctrl = 1'b0;
        u_if.rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk1("s5_post_no_strobe", u_if.sh_control, 1'b0);
            chk1("s5_post_no_valid", u_if.rsp_valid, 1'b0);
        end
        chk1("s5_post_busy", u_if.busy, 1'b0);

        // Scenario 6: six commands alternating direction, amounts 0..5
        for (int i = 0; i < 6; i++) begin
            push_cmd(64'h0000_0000_0000_6000 + 64'(i), 6'(i), ~1'(i), w);
        end
        drain();
        chk("s6_all_issued", 64'(n_issued), 64'(n_pushed));
        chk1("s6_idle_after_drain", u_if.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
